// File: rtl/result_writer_pkg.sv
// rtl/result_writer_pkg.sv - shared types and constants for the result writer
package result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int RESULT_W    = 24;
  localparam int PIX_W       = 8;
  localparam int ADDR_W      = 18;
  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 360;

  // r is the rounded, shifted result; it only needs saturating to the pixel range.
  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [RESULT_W:0] r);
    if (r[RESULT_W]) begin
      return '0;
    end else if (|r[RESULT_W-1:PIX_W]) begin
      return '1;
    end else begin
      return r[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - small circular output buffer; a push into a full buffer
// is accepted only when a pop frees the slot in the same cycle.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign drop  = push && !do_push;

endmodule

// File: rtl/result_writer.sv
// rtl/result_writer.sv - requantizes convolution results to 8-bit pixels and
// writes them to a frame buffer in raster order through a small output buffer.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int FRAME_H    = DEF_FRAME_H,
  parameter int SHIFT      = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_input_valid,
  input  logic [RESULT_W-1:0] io_result,
  input  logic                io_frame_start,
  input  logic                io_wr_ready,
  output logic                io_wr_en,
  output logic [ADDR_W-1:0]   io_wr_addr,
  output logic [PIX_W-1:0]    io_wr_data,
  output logic                io_frame_done,
  output logic                io_overflow,
  output logic                io_busy
);

  localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);
  localparam logic signed [RESULT_W:0] ROUND = (RESULT_W + 1)'(1) << (SHIFT - 1);

  logic signed [RESULT_W:0] sum;
  logic signed [RESULT_W:0] r1_q, r1_d;
  logic                     v1_q, v1_d;
  logic [PIX_W-1:0]         pix2_q, pix2_d;
  logic                     v2_q, v2_d;

  logic [COL_W-1:0]  col_q, col_d, col_b;
  logic [ROW_W-1:0]  row_q, row_d, row_b;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_b;
  state_e            state_q, state_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic             fifo_empty, fifo_drop;
  logic [PIX_W-1:0] fifo_head;
  logic             wr_en, wr_done, last_write;

  result_fifo #(
    .WIDTH(PIX_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clock),
    .rst      (reset),
    .push     (v2_q),
    .push_data(pix2_q),
    .pop      (wr_done),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  always_comb begin
    sum    = $signed({io_result[RESULT_W-1], io_result}) + ROUND;
    r1_d   = sum >>> SHIFT;
    v1_d   = io_input_valid;
    pix2_d = clamp_pix(r1_q);
    v2_d   = v1_q;

    wr_en   = !fifo_empty;
    wr_done = wr_en && io_wr_ready;

    // A frame start rebases the counters first so a coincident write lands on 0.
    col_b  = io_frame_start ? '0 : col_q;
    row_b  = io_frame_start ? '0 : row_q;
    addr_b = io_frame_start ? '0 : addr_q;
    col_d  = col_b;
    row_d  = row_b;
    addr_d = addr_b;
    last_write = wr_done && (col_b == COL_LAST) && (row_b == ROW_LAST);
    if (wr_done) begin
      if (col_b == COL_LAST) begin
        col_d = '0;
        if (row_b == ROW_LAST) begin
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d  = row_b + 1'b1;
          addr_d = addr_b + 1'b1;
        end
      end else begin
        col_d  = col_b + 1'b1;
        addr_d = addr_b + 1'b1;
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (last_write) begin
          state_d = DONE;
        end else if (wr_done || io_frame_start) begin
          state_d = RUN;
        end
      end
      RUN:     if (last_write) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_done_d = (state_d == DONE);
    busy_d       = (state_d == RUN);
    overflow_d   = overflow_q || fifo_drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r1_q         <= '0;
      v1_q         <= 1'b0;
      pix2_q       <= '0;
      v2_q         <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      r1_q         <= r1_d;
      v1_q         <= v1_d;
      pix2_q       <= pix2_d;
      v2_q         <= v2_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign io_wr_en      = wr_en;
  assign io_wr_data    = fifo_empty ? '0 : fifo_head;
  assign io_wr_addr    = addr_q;
  assign io_frame_done = frame_done_q;
  assign io_overflow   = overflow_q;
  assign io_busy       = busy_q;

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - self-checking bench for result_writer on a 4x2 frame
module tb_result_writer;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int SH = 14;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_input_valid = 1'b0;
  logic [23:0] io_result = '0;
  logic        io_frame_start = 1'b0;
  logic        io_wr_ready = 1'b0;
  logic        io_wr_en;
  logic [17:0] io_wr_addr;
  logic [7:0]  io_wr_data;
  logic        io_frame_done;
  logic        io_overflow;
  logic        io_busy;

  result_writer #(
    .FRAME_W(FW),
    .FRAME_H(FH),
    .SHIFT(SH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_input_valid(io_input_valid),
    .io_result     (io_result),
    .io_frame_start(io_frame_start),
    .io_wr_ready   (io_wr_ready),
    .io_wr_en      (io_wr_en),
    .io_wr_addr    (io_wr_addr),
    .io_wr_data    (io_wr_data),
    .io_frame_done (io_frame_done),
    .io_overflow   (io_overflow),
    .io_busy       (io_busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round-half-up division by 2^SH with floor semantics, then saturate.
  function automatic int quant(input logic [23:0] x);
    int v, d, q;
    v = int'($signed(x));
    d = v + (1 << (SH - 1));
    if (d >= 0) q = d / (1 << SH);
    else q = -((-d + (1 << SH) - 1) / (1 << SH));
    if (q < 0) return 0;
    if (q > 255) return 255;
    return q;
  endfunction

  // Model: pixels reach the buffer two edges after sampling; state 0/1/2 = idle/run/done.
  int mq[$];
  int pend_val[$];
  int pend_due[$];
  int m_addr = 0, m_state = 0, m_ovf = 0, cyc = 0, m_v;
  bit m_wd, m_last;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      pend_val.delete();
      pend_due.delete();
      m_addr = 0;
      m_state = 0;
      m_ovf = 0;
    end else begin
      m_wd = (mq.size() > 0) && io_wr_ready;
      m_last = m_wd && !io_frame_start && (m_addr == FW * FH - 1);
      if (m_state == 2) m_state = 0;
      else if (m_last) m_state = 2;
      else if (m_state == 0 && (m_wd || io_frame_start)) m_state = 1;
      if (io_frame_start) m_addr = 0;
      if (m_wd) begin
        void'(mq.pop_front());
        m_addr = (m_addr + 1) % (FW * FH);
      end
      while (pend_due.size() > 0 && pend_due[0] == cyc) begin
        m_v = pend_val.pop_front();
        void'(pend_due.pop_front());
        if (mq.size() < DEPTH) mq.push_back(m_v);
        else m_ovf = 1;
      end
      if (io_input_valid) begin
        pend_val.push_back(quant(io_result));
        pend_due.push_back(cyc + 2);
      end
    end
    cyc++;
  end

  always @(posedge clock) begin
    #2;
    if (!reset) begin
      chk("wr_en", int'(io_wr_en), (mq.size() > 0) ? 1 : 0);
      chk("wr_data", int'(io_wr_data), (mq.size() > 0) ? mq[0] : 0);
      chk("wr_addr", int'(io_wr_addr), m_addr);
      chk("frame_done", int'(io_frame_done), (m_state == 2) ? 1 : 0);
      chk("busy", int'(io_busy), (m_state == 1) ? 1 : 0);
      chk("overflow", int'(io_overflow), m_ovf);
    end
  end

  int log_addr[$];
  int log_data[$];
  int fd_count = 0;
  int fd_prev = -1;

  always @(negedge clock) begin
    if (!reset) begin
      if (io_frame_done) begin
        fd_count++;
        fd_prev = (log_addr.size() > 0) ? log_addr[$] : -1;
      end
      if (io_wr_en && io_wr_ready) begin
        log_addr.push_back(int'(io_wr_addr));
        log_data.push_back(int'(io_wr_data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #4;
  endtask

  task automatic do_reset();
    io_input_valid = 1'b0;
    io_frame_start = 1'b0;
    reset = 1'b1;
    log_addr.delete();
    log_data.delete();
    fd_count = 0;
    fd_prev = -1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_en"}, int'(io_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(io_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(io_wr_data), 0);
    chk({tag, "_frame_done"}, int'(io_frame_done), 0);
    chk({tag, "_overflow"}, int'(io_overflow), 0);
    chk({tag, "_busy"}, int'(io_busy), 0);
  endtask

  logic [23:0] rq_vals [5] = '{24'h004000, 24'h002000, 24'h001FFF, 24'hFFC000, 24'h7FFFFF};
  int rq_exp [5] = '{1, 1, 0, 0, 255};
  int a24_exp [8] = '{0, 1, 2, 3, 4, 5, 1, 2};
  bit found;
  bit fs_done;

  initial begin
    do_reset();
    chk_zero_outputs("reset");
    chk("model_q_pos", quant(24'h004000), 1);
    chk("model_q_neg", quant(24'hFFC000), 0);
    chk("model_q_sat", quant(24'h7FFFFF), 255);

    // Latency of a single result with the write port ready.
    io_wr_ready = 1'b1;
    tick();
    io_input_valid = 1'b1;
    io_result = rq_vals[0];
    @(posedge clock);
    #1 chk("lat_e0_wr_en", int'(io_wr_en), 0);
    io_input_valid = 1'b0;
    @(posedge clock);
    #1 chk("lat_e1_wr_en", int'(io_wr_en), 0);
    @(posedge clock);
    #1;
    chk("lat_e2_wr_en", int'(io_wr_en), 1);
    chk("lat_e2_addr", int'(io_wr_addr), 0);
    chk("lat_e2_data", int'(io_wr_data), 1);
    tick();
    for (int i = 1; i < 5; i++) begin
      io_input_valid = 1'b1;
      io_result = rq_vals[i];
      tick();
    end
    io_input_valid = 1'b0;
    repeat (6) tick();
    chk("rq_count", log_data.size(), 5);
    for (int i = 0; i < 5 && i < log_data.size(); i++) begin
      chk($sformatf("rq_data%0d", i), log_data[i], rq_exp[i]);
      chk($sformatf("rq_addr%0d", i), log_addr[i], i);
    end

    // Full 4x2 frame plus one pixel wrapping to address 0.
    do_reset();
    io_wr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      io_input_valid = 1'b1;
      io_result = 24'((20 + i) << 14);
      tick();
    end
    io_input_valid = 1'b0;
    repeat (8) tick();
    chk("frame_count", log_addr.size(), 9);
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      chk($sformatf("frame_addr%0d", i), log_addr[i], (i < 8) ? i : 0);
    end
    if (log_data.size() == 9) chk("frame_data8", log_data[8], 28);
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_after", fd_prev, 7);

    // Write port stalled while results keep arriving.
    do_reset();
    io_wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      io_input_valid = (i < 8);
      io_result = 24'((10 + i) << 14);
      tick();
      if (i == 5) chk("stall_ovf_before", int'(io_overflow), 0);
      if (i == 6) chk("stall_ovf_set", int'(io_overflow), 1);
      if (i >= 2) chk($sformatf("stall_head%0d", i), int'(io_wr_data), 10);
    end
    io_wr_ready = 1'b1;
    io_input_valid = 1'b0;
    repeat (8) tick();
    chk("stall_count", log_data.size(), 4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      chk($sformatf("stall_data%0d", i), log_data[i], 10 + i);
      chk($sformatf("stall_addr%0d", i), log_addr[i], i);
    end
    chk("stall_ovf_sticky", int'(io_overflow), 1);

    // Reset mid-frame after three writes.
    do_reset();
    io_wr_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      io_input_valid = (k < 6);
      io_result = 24'((40 + k) << 14);
      tick();
      if (log_addr.size() >= 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_reached_3_writes", int'(found), 1);
    io_input_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    chk("midrst_count", log_addr.size(), 3);
    tick();
    tick();
    reset = 1'b0;
    io_input_valid = 1'b1;
    io_result = 24'(50 << 14);
    tick();
    io_input_valid = 1'b0;
    repeat (6) tick();
    chk("midrst_after_count", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("midrst_after_addr", log_addr[3], 0);
      chk("midrst_after_data", log_data[3], 50);
    end

    // Frame start coinciding with the write to address 5.
    do_reset();
    io_wr_ready = 1'b1;
    fs_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      io_input_valid = (k < 8);
      io_result = 24'((60 + k) << 14);
      io_frame_start = !fs_done && io_wr_en && (io_wr_addr == 18'd5);
      if (io_frame_start) fs_done = 1'b1;
      tick();
    end
    io_frame_start = 1'b0;
    io_input_valid = 1'b0;
    chk("fs_hit_addr5", int'(fs_done), 1);
    chk("fs_count", log_addr.size(), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      chk($sformatf("fs_addr%0d", i), log_addr[i], a24_exp[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
